// File: rtl/barker_spreading.sv
// 802.11b DSSS spreader: differential BPSK/QPSK symbol mapping followed by
// 11-chip Barker spreading, one registered I/Q sample per chip strobe.
module barker_spreading #(
  parameter logic [15:0] AMP = 16'd8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe_chip,
  input  logic [1:0]  bits_in,
  input  logic        rate,
  input  logic        bits_valid,
  output logic        bits_ready,
  output logic [15:0] dataouti,
  output logic [15:0] dataoutq,
  output logic        strobe_out,
  output logic        symbol_start,
  output logic        underrun
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] NEG_AMP = ~AMP + 16'd1;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [1:0]  phase, phase_nxt;
  logic        hold_full, hold_full_nxt;
  logic [1:0]  hold_bits;
  logic        hold_rate;
  logic [1:0]  delta;
  logic        load, emit, go_idle, accept, chip_neg;
  logic [3:0]  chip_idx;
  logic [15:0] sample_i, sample_q;

  // Handshake: a symbol transfers on a rising clk edge where bits_valid and
  // bits_ready are both high. bits_ready is a register (holding register
  // empty), so it never depends combinationally on bits_valid.
  assign accept = bits_valid && bits_ready;

  function automatic logic barker_neg(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd4, 4'd8, 4'd9, 4'd10: barker_neg = 1'b1;
      default:                       barker_neg = 1'b0;
    endcase
  endfunction

  always_comb begin
    delta = 2'd0;
    if (!hold_rate) begin
      delta = hold_bits[0] ? 2'd2 : 2'd0;
    end else begin
      case ({hold_bits[0], hold_bits[1]})
        2'b00:   delta = 2'd0;
        2'b01:   delta = 2'd1;
        2'b11:   delta = 2'd2;
        default: delta = 2'd3;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    phase_nxt = phase;
    load      = 1'b0;
    emit      = 1'b0;
    go_idle   = 1'b0;
    chip_idx  = cnt;
    if (strobe_chip) begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            load      = 1'b1;
            emit      = 1'b1;
            phase_nxt = delta;
            cnt_nxt   = 4'd1;
            chip_idx  = 4'd0;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (cnt != 4'd0) begin
            emit    = 1'b1;
            cnt_nxt = (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
          end else if (hold_full) begin
            load      = 1'b1;
            emit      = 1'b1;
            phase_nxt = phase + delta;
            cnt_nxt   = 4'd1;
          end else begin
            go_idle   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    hold_full_nxt = hold_full;
    if (load) begin
      hold_full_nxt = 1'b0;
    end else if (accept) begin
      hold_full_nxt = 1'b1;
    end

    // Symbol value lies on one axis; the Barker chip only flips its sign.
    chip_neg = barker_neg(chip_idx);
    sample_i = 16'd0;
    sample_q = 16'd0;
    if (!phase_nxt[0]) begin
      sample_i = (phase_nxt[1] ^ chip_neg) ? NEG_AMP : AMP;
    end else begin
      sample_q = (phase_nxt[1] ^ chip_neg) ? NEG_AMP : AMP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      phase        <= 2'd0;
      hold_full    <= 1'b0;
      hold_bits    <= 2'd0;
      hold_rate    <= 1'b0;
      bits_ready   <= 1'b0;
      dataouti     <= 16'd0;
      dataoutq     <= 16'd0;
      strobe_out   <= 1'b0;
      symbol_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      phase        <= phase_nxt;
      hold_full    <= hold_full_nxt;
      bits_ready   <= !hold_full_nxt;
      strobe_out   <= emit;
      symbol_start <= emit && (chip_idx == 4'd0);
      underrun     <= go_idle;
      if (accept) begin
        hold_bits <= bits_in;
        hold_rate <= rate;
      end
      if (emit) begin
        dataouti <= sample_i;
        dataoutq <= sample_q;
      end else if (go_idle) begin
        dataouti <= 16'd0;
        dataoutq <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_barker_spreading.sv
// Bench for barker_spreading: symbol-level reference model feeding an expected
// sample queue, per-cycle output monitor, directed scenarios plus random traffic.
module tb_barker_spreading;

  localparam int AMP = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe_chip;
  logic [1:0]  bits_in;
  logic        rate;
  logic        bits_valid;
  logic        bits_ready;
  logic [15:0] dataouti, dataoutq;
  logic        strobe_out, symbol_start, underrun;

  barker_spreading #(.AMP(16'd8192)) dut (
    .clk(clk), .reset(reset), .strobe_chip(strobe_chip), .bits_in(bits_in),
    .rate(rate), .bits_valid(bits_valid), .bits_ready(bits_ready),
    .dataouti(dataouti), .dataoutq(dataoutq), .strobe_out(strobe_out),
    .symbol_start(symbol_start), .underrun(underrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int barker[11] = '{1, -1, 1, 1, -1, 1, 1, 1, -1, -1, -1};
  int dq_delta[4] = '{0, 1, 3, 2};   // index = 2*d0 + d1

  logic [32:0] exp_q[$];             // {symbol_start, I, Q}
  int  cur_i[11], cur_q[11];
  int  m_pos = 0, m_phase = 0;
  bit  m_burst = 0, m_held = 0, m_ready = 0;
  logic [1:0] m_hbits = 2'b00;
  logic m_hrate = 1'b0;
  int  e_i = 0, e_q = 0;
  bit  e_strobe = 0, e_start = 0, e_underrun = 0, e_ready = 0;

  function automatic int delta_of(input logic [1:0] b, input logic r);
    if (!r) return b[0] ? 2 : 0;
    return dq_delta[2 * int'(b[0]) + int'(b[1])];
  endfunction

  task automatic model_emit(input int k, input bit start);
    exp_q.push_back({start, 16'(cur_i[k]), 16'(cur_q[k])});
    e_strobe = 1; e_start = start; e_i = cur_i[k]; e_q = cur_q[k];
  endtask

  task automatic model_load();
    int bi, bq;
    m_phase = ((m_burst ? m_phase : 0) + delta_of(m_hbits, m_hrate)) % 4;
    bi = (m_phase == 0) ? AMP : (m_phase == 2) ? -AMP : 0;
    bq = (m_phase == 1) ? AMP : (m_phase == 3) ? -AMP : 0;
    for (int k = 0; k < 11; k++) begin
      cur_i[k] = barker[k] * bi;
      cur_q[k] = barker[k] * bq;
    end
  endtask

  always @(posedge clk) begin
    e_strobe = 0; e_start = 0; e_underrun = 0;
    if (reset) begin
      m_pos = 0; m_phase = 0; m_burst = 0; m_held = 0; m_ready = 0;
      e_i = 0; e_q = 0; exp_q.delete();
    end else begin
      if (strobe_chip) begin
        if (m_burst && m_pos < 11) begin
          model_emit(m_pos, 0);
          m_pos++;
        end else if (m_held) begin
          model_load();
          model_emit(0, 1);
          m_pos = 1; m_burst = 1; m_held = 0;
        end else if (m_burst) begin
          m_burst = 0; e_underrun = 1; e_i = 0; e_q = 0;
        end
      end
      if (bits_valid && m_ready) begin
        m_held = 1; m_hbits = bits_in; m_hrate = rate;
      end
      m_ready = !m_held;
    end
    e_ready = m_ready;
  end

  // ---------------- monitor / scoreboard ----------------
  bit mon_en = 0;
  logic [31:0] cap[$];
  int u_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("strobe_out", strobe_out, e_strobe);
        chk("underrun", underrun, e_underrun);
        chk("bits_ready", bits_ready, e_ready);
        chk("symbol_start", symbol_start, e_start);
        if (strobe_out) begin
          cap.push_back({dataouti, dataoutq});
          if (exp_q.size() == 0) begin
            chk("unexpected_sample", 1, 0);
          end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            chk("sample_i", $signed(dataouti), $signed(e[31:16]));
            chk("sample_q", $signed(dataoutq), $signed(e[15:0]));
          end
        end else begin
          chk("hold_i", $signed(dataouti), e_i);
          chk("hold_q", $signed(dataoutq), e_q);
        end
        if (underrun) u_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  bit strobe_en = 0;
  int spacing = 3;

  initial begin
    int sc = 0;
    strobe_chip = 1'b0;
    forever begin
      @(negedge clk);
      if (strobe_en && sc >= spacing - 1) begin
        strobe_chip = 1'b1; sc = 0;
      end else begin
        strobe_chip = 1'b0; sc++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_sym(input logic [1:0] b, input logic r);
    bit ok = 0;
    bit rdy;
    bits_valid = 1'b1; bits_in = b; rate = r;
    for (int n = 0; n < 300 && !ok; n++) begin
      rdy = bits_ready;
      @(negedge clk);
      if (rdy) ok = 1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    bits_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_i031[11] = '{-8192, 8192, -8192, -8192, 8192, -8192, -8192, -8192, 8192, 8192, 8192};
  logic [1:0]  syms[6];
  logic        srate[6];
  logic [31:0] cap_a[$];
  int u0;

  initial begin
    reset = 1'b1; bits_valid = 1'b0; bits_in = 2'b00; rate = 1'b0;
    @(posedge clk);
    mon_en = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // One DBPSK symbol d0=1, then 12 strobes.
    send_sym(2'b01, 1'b0);
    cap.delete(); u0 = u_cnt;
    spacing = 3; strobe_en = 1;
    repeat (45) @(negedge clk);
    chk("dbpsk_count", cap.size(), 11);
    for (int k = 0; k < 11 && k < cap.size(); k++) begin
      chk("dbpsk_i", $signed(cap[k][31:16]), exp_i031[k]);
      chk("dbpsk_q", $signed(cap[k][15:0]), 0);
    end
    chk("dbpsk_underrun", u_cnt - u0, 1);

    // New burst after underrun restarts phase at 0.
    cap.delete();
    send_sym(2'b00, 1'b0);
    repeat (45) @(negedge clk);
    chk("restart_count", cap.size(), 11);
    if (cap.size() > 0) begin
      chk("restart_i0", $signed(cap[0][31:16]), 8192);
      chk("restart_q0", $signed(cap[0][15:0]), 0);
    end

    // DQPSK 01, 01, 11 back-to-back.
    cap.delete(); spacing = 2;
    send_sym(2'b10, 1'b1);   // {d1,d0}: d0=0,d1=1 -> "01"
    send_sym(2'b10, 1'b1);
    send_sym(2'b11, 1'b1);
    repeat (80) @(negedge clk);
    chk("dqpsk_count", cap.size(), 33);
    if (cap.size() >= 23) begin
      chk("dqpsk_s0_i", $signed(cap[0][31:16]), 0);
      chk("dqpsk_s0_q", $signed(cap[0][15:0]), 8192);
      chk("dqpsk_s1_i", $signed(cap[11][31:16]), -8192);
      chk("dqpsk_s1_q", $signed(cap[11][15:0]), 0);
      chk("dqpsk_s2_i", $signed(cap[22][31:16]), 8192);
      chk("dqpsk_s2_q", $signed(cap[22][15:0]), 0);
    end

    // Reset in the middle of a symbol with another symbol held.
    spacing = 3;
    send_sym(2'b01, 1'b1);
    send_sym(2'b11, 1'b1);
    for (int n = 0; n < 200 && m_pos != 5; n++) @(negedge clk);
    chk("reach_chip5", m_pos, 5);
    pulse_reset();
    cap.delete();
    repeat (40) @(negedge clk);
    chk("post_reset_silent", cap.size(), 0);

    // Same symbols at strobe spacing 2 and 8 give the same samples.
    for (int k = 0; k < 6; k++) begin
      syms[k] = 2'($urandom_range(0, 3));
      srate[k] = 1'($urandom_range(0, 1));
    end
    for (int pass = 0; pass < 2; pass++) begin
      pulse_reset();
      spacing = (pass == 0) ? 2 : 8;
      cap.delete();
      for (int k = 0; k < 6; k++) send_sym(syms[k], srate[k]);
      repeat (12 * spacing * 7) @(negedge clk);
      if (pass == 0) cap_a = cap;
    end
    chk("rate_cmp_len", cap.size(), 66);
    chk("rate_cmp_len_a", cap_a.size(), 66);
    for (int k = 0; k < 66 && k < cap.size() && k < cap_a.size(); k++)
      chk("rate_cmp_sample", int'(cap[k]), int'(cap_a[k]));

    // Random traffic.
    for (int round = 0; round < 3; round++) begin
      spacing = $urandom_range(2, 6);
      for (int n = 0; n < 300; n++) begin
        bits_valid = ($urandom_range(0, 2) == 0);
        bits_in = 2'($urandom_range(0, 3));
        rate = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bits_valid = 1'b0;
      repeat (100) @(negedge clk);
    end
    chk("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/barker_spreading.md
BARKER_SPREADING -- requirements
Module: barker_spreading

Interface
REQ-001 SHALL have parameter AMP, default 16'd8192, the chip amplitude magnitude (two's complement, positive, below 16'h8000).
REQ-002 SHALL have port clk  input  1  system clock; the block has one clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port strobe_chip  input  1  chip-rate enable (11 Mchip/s), one-cycle pulses, at least 2 cycles apart.
REQ-005 SHALL have port bits_in  input  2  symbol bits {d1,d0}; d0 only is used at 1 Mbps.
REQ-006 SHALL have port rate  input  1  0 = DBPSK 1 Mbps, 1 = DQPSK 2 Mbps; sampled together with bits_in.
REQ-007 SHALL have port bits_valid  input  1  bits_in and rate are valid.
REQ-008 SHALL have port bits_ready  output  1  the block can accept a symbol.
REQ-009 SHALL have port dataouti  output  16  signed I chip sample.
REQ-010 SHALL have port dataoutq  output  16  signed Q chip sample.
REQ-011 SHALL have port strobe_out  output  1  dataouti/dataoutq valid, one-cycle pulse.
REQ-012 SHALL have port symbol_start  output  1  coincides with strobe_out for chip 0 of each symbol.
REQ-013 SHALL have port underrun  output  1  one-cycle pulse when a burst ends because no symbol was available.

Function
REQ-014 SHALL hold one symbol (bits, rate) in a holding register; bits_ready = holding register empty, registered, with no combinational path from bits_valid.
REQ-015 SHALL accept a symbol on any cycle where bits_valid && bits_ready; if the holding register is emptied and a symbol is offered in the same cycle, that symbol is not accepted (bits_ready was low).
REQ-016 SHALL implement a two-state FSM, IDLE and RUN, with a chip index cnt in 0..10 (the next chip to emit), wrapping 10 -> 0.
REQ-017 In IDLE, on strobe_chip with the holding register full: clear the phase reference to 0, load the symbol, emit chip 0, set cnt to 1, and go to RUN; with the holding register empty: no output, stay IDLE.
REQ-018 In RUN, on strobe_chip with cnt != 0: emit chip cnt of the current symbol and increment cnt (wrapping after 10).
REQ-019 In RUN, on strobe_chip with cnt == 0 and the holding register full: load the symbol, emit chip 0, set cnt to 1.
REQ-020 In RUN, on strobe_chip with cnt == 0 and the holding register empty: go to IDLE, pulse underrun the next cycle, and produce no strobe_out.
REQ-021 On a load: phase <= phase + delta (mod 4, in units of pi/2), and the holding register becomes empty.
REQ-022 DBPSK: d0 = 0 -> delta 0; d0 = 1 -> delta 2.
REQ-023 DQPSK: {d0,d1} = 00 -> 0, 01 -> 1, 11 -> 2, 10 -> 3.
REQ-024 Phase maps to the symbol value: 0 -> (+AMP, 0); 1 -> (0, +AMP); 2 -> (-AMP, 0); 3 -> (0, -AMP).
REQ-025 Barker chips 0..10 SHALL be +1 -1 +1 +1 -1 +1 +1 +1 -1 -1 -1; output = chip × symbol value; -AMP is the exact two's-complement negation, and zero components stay 0.
REQ-026 Latency: strobe_chip at cycle N -> strobe_out, dataouti/q and symbol_start registered at cycle N+1.
REQ-027 dataouti/q SHALL hold their last value between strobes and return to 0 on entering IDLE.

Reset
REQ-028 While reset is high at a clock edge: state IDLE, cnt 0, phase 0, holding register empty, bits_ready 0; dataouti/q 0; strobe_out, symbol_start and underrun 0.
REQ-029 bits_ready SHALL go to 1 on the first cycle after reset deasserts.
REQ-030 Reset mid-symbol SHALL abort the symbol immediately and discard the held symbol, with no underrun pulse.

Verification
REQ-031 One DBPSK symbol d0 = 1, then strobes -> 11 strobe_out; I = -8192, +8192, -8192, -8192, +8192, -8192, -8192, -8192, +8192, +8192, +8192; Q = 0; symbol_start on the first; underrun on the 12th strobe.
REQ-032 DQPSK symbols 01, 01, 11 back-to-back -> phases 1, 2, 0; chip 0 of each = (0, +8192), (-8192, 0), (+8192, 0); no gaps; 33 strobe_out.
REQ-033 bits_valid held high continuously -> bits_ready low except for one cycle after each load; every accepted symbol is emitted exactly once, in order.
REQ-034 Symbol arrives after underrun -> the new burst phase reference is 0; d0 = 0 gives chip 0 = (+8192, 0).
REQ-035 Reset asserted at chip 5 with a symbol held -> the next cycle all outputs are 0; after release no strobe_out until a new symbol is accepted.
REQ-036 strobe_chip every 2 cycles versus every 8 cycles -> identical sample sequences; each strobe_out exactly 1 cycle after its strobe.
